// File: rtl/fila_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : fila_serial_tx
// Purpose  : Dumps the request queue (address 0 up to the first empty entry)
//            as UART 8N1 frames. Optional: FILA_SERIAL_TERMINADOR_EN adds an
//            0x0A frame after the last entry.
// Revision : 1.0 - initial release
// ============================================================================
module fila_serial_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int PROFUNDIDADE = 16
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       enviar,
    input  logic [5:0] dados_addrSerial,
    input  logic       eh_origem_addrSerial,
    output logic [3:0] addrSerial,
    output logic       saida_serial,
    output logic       ocupado,
    output logic       pronto,
    output logic [4:0] num_enviados
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] c_BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_ONE      = CW'(1);
    localparam logic [4:0]    c_PROF     = 5'(PROFUNDIDADE);
`ifdef FILA_SERIAL_TERMINADOR_EN
    localparam logic [7:0]    c_TERMINADOR = 8'h0A;
`endif

    typedef enum logic [2:0] {
        INICIAL    = 3'd0,
        ENDERECA   = 3'd1,
        LE         = 3'd2,
        TRANSMITE  = 3'd3,
        TERMINADOR = 3'd4,
        FIM        = 3'd5
    } state_t;

    state_t        state, state_next;
    logic [4:0]    r_idx;
    logic [9:0]    r_shift;
    logic [CW-1:0] r_clk_cnt;
    logic [3:0]    r_bit_cnt;

    logic [7:0]    w_byte;
    logic          w_vazia;
    logic          w_bit_end;
    logic          w_frame_end;
    logic [4:0]    w_idx_inc;

    assign w_byte       = {1'b0, eh_origem_addrSerial, dados_addrSerial};
    assign w_vazia      = (w_byte[6:0] == 7'd0);
    assign w_bit_end    = (r_clk_cnt == c_BIT_LAST);
    assign w_frame_end  = w_bit_end && (r_bit_cnt == 4'd9);
    assign w_idx_inc    = r_idx + 5'd1;
    // Shift register refills with ones, so the line idles high between frames.
    assign saida_serial = r_shift[0];

    always_ff @(posedge clk) begin
        if (clear) state <= INICIAL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            INICIAL:  if (enviar) state_next = ENDERECA;
            ENDERECA: state_next = LE;
            LE: begin
                if (w_vazia) begin
`ifdef FILA_SERIAL_TERMINADOR_EN
                    state_next = TERMINADOR;
`else
                    state_next = FIM;
`endif
                end else begin
                    state_next = TRANSMITE;
                end
            end
            TRANSMITE: begin
                if (w_frame_end) begin
                    if (w_idx_inc == c_PROF) begin
`ifdef FILA_SERIAL_TERMINADOR_EN
                        state_next = TERMINADOR;
`else
                        state_next = FIM;
`endif
                    end else begin
                        state_next = ENDERECA;
                    end
                end
            end
            TERMINADOR: if (w_frame_end) state_next = FIM;
            FIM:        state_next = INICIAL;
            default:    state_next = INICIAL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_idx        <= '0;
            r_shift      <= '1;
            r_clk_cnt    <= '0;
            r_bit_cnt    <= '0;
            addrSerial   <= '0;
            ocupado      <= 1'b0;
            pronto       <= 1'b0;
            num_enviados <= '0;
        end else begin
            pronto <= (state_next == FIM);
            case (state)
                INICIAL: begin
                    if (enviar) begin
                        r_idx        <= '0;
                        num_enviados <= '0;
                        ocupado      <= 1'b1;
                        addrSerial   <= '0;
                    end
                end
                LE: begin
                    r_clk_cnt <= '0;
                    r_bit_cnt <= '0;
                    if (!w_vazia) r_shift <= {1'b1, w_byte, 1'b0};
`ifdef FILA_SERIAL_TERMINADOR_EN
                    else          r_shift <= {1'b1, c_TERMINADOR, 1'b0};
`endif
                end
                TRANSMITE, TERMINADOR: begin
                    if (w_bit_end) begin
                        r_clk_cnt <= '0;
                        r_shift   <= {1'b1, r_shift[9:1]};
                        r_bit_cnt <= w_frame_end ? 4'd0 : r_bit_cnt + 4'd1;
                    end else begin
                        r_clk_cnt <= r_clk_cnt + c_ONE;
                    end
                    if (state == TRANSMITE && w_frame_end) begin
                        num_enviados <= num_enviados + 5'd1;
                        r_idx        <= w_idx_inc;
                        // Address only advances when another entry will be read,
                        // so a full queue leaves addrSerial on the last entry.
                        if (state_next == ENDERECA) addrSerial <= w_idx_inc[3:0];
`ifdef FILA_SERIAL_TERMINADOR_EN
                        if (state_next == TERMINADOR) r_shift <= {1'b1, c_TERMINADOR, 1'b0};
`endif
                    end
                end
                FIM:     ocupado <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_fila_serial_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_fila_serial_tx
// Purpose  : Self-checking bench for fila_serial_tx with a registered-read RAM
//            model, a UART frame monitor and a queue-level expected-byte model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fila_serial_tx;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       enviar = 1'b0;
    logic [5:0] dados;
    logic       eh;
    logic [3:0] addr;
    logic       saida, ocupado, pronto;
    logic [4:0] num;

    logic [6:0] ram [16];
    logic [6:0] rd;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] exp_q[$];
    int         exp_cnt;

    fila_serial_tx #(.CLKS_PER_BIT(CPB), .PROFUNDIDADE(16)) dut (
        .clk                 (clk),
        .clear               (clear),
        .enviar              (enviar),
        .dados_addrSerial    (dados),
        .eh_origem_addrSerial(eh),
        .addrSerial          (addr),
        .saida_serial        (saida),
        .ocupado             (ocupado),
        .pronto              (pronto),
        .num_enviados        (num)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd <= ram[addr];
    assign dados = rd[5:0];
    assign eh    = rd[6];

    // UART monitor: decodes frames, checks every bit is CPB samples wide.
    logic [7:0] rx_q[$];
    logic       line_s [10*CPB];
    logic [7:0] mon_byte;
    int         mon_cnt = 0, start_cnt = 0, frame_err = 0, pronto_cnt = 0;

    always @(negedge clk) begin
        if (pronto === 1'b1) pronto_cnt++;
        if (clear) begin
            mon_cnt = 0;
        end else if (mon_cnt == 0) begin
            if (saida === 1'b0) begin
                line_s[0] = 1'b0;
                mon_cnt = 1;
                start_cnt++;
            end
        end else begin
            line_s[mon_cnt] = saida;
            mon_cnt++;
            if (mon_cnt == 10*CPB) begin
                for (int i = 0; i < 10; i++)
                    for (int j = 1; j < CPB; j++)
                        if (line_s[i*CPB+j] !== line_s[i*CPB]) frame_err++;
                if (line_s[9*CPB] !== 1'b1) frame_err++;
                for (int i = 0; i < 8; i++) mon_byte[i] = line_s[(i+1)*CPB];
                rx_q.push_back(mon_byte);
                mon_cnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected output: entries from address 0 up to the first empty one.
    task automatic build_exp();
        bit stop;
        exp_q.delete();
        stop = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (ram[i] == 7'd0) stop = 1'b1;
            if (!stop) exp_q.push_back({1'b0, ram[i]});
        end
        exp_cnt = exp_q.size();
`ifdef FILA_SERIAL_TERMINADOR_EN
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic do_dump(input string tag, input bit again, output int p_at);
        int n, rx_base, pr_base, fe_base, st_base, dec, again_cnt;
        bit sent_again;
        logic [3:0] pa;
        build_exp();
        rx_base = rx_q.size();
        pr_base = pronto_cnt;
        fe_base = frame_err;
        st_base = start_cnt;
        @(negedge clk); enviar = 1'b1;
        @(negedge clk); enviar = 1'b0;
        check({tag, "_busy"}, ocupado, 1);
        n = 1; p_at = 0; dec = 0; sent_again = 1'b0; again_cnt = 0; pa = addr;
        while (p_at == 0 && n < 3000) begin
            if (pronto === 1'b1) p_at = n;
            if (addr < pa) dec++;
            pa = addr;
            enviar = 1'b0;
            if (again && !sent_again && rx_q.size() >= rx_base + 1) begin
                again_cnt++;
                if (again_cnt == 10) begin
                    enviar = 1'b1;
                    sent_again = 1'b1;
                end
            end
            if (p_at == 0) begin
                @(negedge clk);
                n++;
            end
        end
        enviar = 1'b0;
        repeat (4) @(negedge clk);
        check({tag, "_pronto_seen"}, 32'(p_at != 0), 1);
        check({tag, "_frames"}, rx_q.size() - rx_base, exp_q.size());
        check({tag, "_starts"}, start_cnt - st_base, exp_q.size());
        for (int k = 0; k < exp_q.size(); k++)
            if (rx_base + k < rx_q.size())
                check({tag, "_byte"}, rx_q[rx_base+k], exp_q[k]);
        check({tag, "_num_enviados"}, num, exp_cnt);
        check({tag, "_pronto_pulses"}, pronto_cnt - pr_base, 1);
        check({tag, "_frame_shape"}, frame_err - fe_base, 0);
        check({tag, "_idle_busy"}, ocupado, 0);
        check({tag, "_idle_line"}, saida, 1);
        check({tag, "_addr_monotonic"}, dec, 0);
    endtask

    initial begin
        int p, n, len, rx_base, pr_base, st_base;

        for (int i = 0; i < 16; i++) ram[i] = 7'd0;
        repeat (3) @(negedge clk);
        clear = 1'b0;
        repeat (20) @(negedge clk);
        check("rst_line", saida, 1);
        check("rst_busy", ocupado, 0);
        check("rst_addr", addr, 0);
        check("rst_num", num, 0);
        check("rst_pronto", pronto, 0);

        // Single entry 0x5A
        ram[0] = 7'h5A;
        do_dump("one", 1'b0, p);

        // Full queue, RAM[i] = i+1
        for (int i = 0; i < 16; i++) ram[i] = 7'(i + 1);
        do_dump("full", 1'b0, p);
        check("full_addr_end", addr, 15);

        // Empty queue
        for (int i = 0; i < 16; i++) ram[i] = 7'd0;
        do_dump("empty", 1'b0, p);
`ifndef FILA_SERIAL_TERMINADOR_EN
        check("empty_pronto_latency", p, 3);
`endif

        // Three entries, enviar repeated during the 2nd frame
        ram[0] = 7'h21; ram[1] = 7'h7F; ram[2] = 7'h03;
        do_dump("again", 1'b1, p);

        // Random queue contents
        for (int t = 0; t < 3; t++) begin
            len = $urandom_range(1, 16);
            for (int i = 0; i < 16; i++) begin
                if (i < len)       ram[i] = 7'($urandom_range(1, 127));
                else if (i == len) ram[i] = 7'd0;
                else               ram[i] = 7'($urandom);
            end
            do_dump("rand", 1'b0, p);
        end

        // Clear in the middle of data bit 0 of the first frame
        for (int i = 0; i < 16; i++) ram[i] = 7'd0;
        ram[0] = 7'h5A; ram[1] = 7'h11;
        rx_base = rx_q.size();
        pr_base = pronto_cnt;
        st_base = start_cnt;
        @(negedge clk); enviar = 1'b1;
        @(negedge clk); enviar = 1'b0;
        n = 0;
        while (saida !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("clr_start_seen", saida, 0);
        repeat (5) @(negedge clk);
        check("clr_pre_line", saida, 0);
        clear = 1'b1;
        @(negedge clk);
        check("clr_line_high", saida, 1);
        check("clr_not_busy", ocupado, 0);
        @(negedge clk);
        clear = 1'b0;
        repeat (200) @(negedge clk);
        check("clr_no_pronto", pronto_cnt - pr_base, 0);
        check("clr_no_frames", rx_q.size() - rx_base, 0);
        check("clr_one_start", start_cnt - st_base, 1);
        check("clr_line_idle", saida, 1);
        check("clr_num", num, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
